// File: rtl/mem_lsu_pkg.sv
// Shared load/store definitions: aluop encodings, LSU FSM states, big-endian byte-lane selects.
// Reused by the execute stage so both sides agree on the memory-op encodings.
package mem_lsu_pkg;

  localparam logic [7:0] OpLb  = 8'hE0;
  localparam logic [7:0] OpLh  = 8'hE1;
  localparam logic [7:0] OpLwl = 8'hE2;
  localparam logic [7:0] OpLw  = 8'hE3;
  localparam logic [7:0] OpLbu = 8'hE4;
  localparam logic [7:0] OpLhu = 8'hE5;
  localparam logic [7:0] OpLwr = 8'hE6;
  localparam logic [7:0] OpSb  = 8'hE8;
  localparam logic [7:0] OpSh  = 8'hE9;
  localparam logic [7:0] OpSwl = 8'hEA;
  localparam logic [7:0] OpSw  = 8'hEB;
  localparam logic [7:0] OpSwr = 8'hEE;

  // Lane select bit 3 addresses byte 0 (bits [31:24]) of the word.
  localparam logic [3:0] SelNone = 4'b0000;
  localparam logic [3:0] SelB0   = 4'b1000;
  localparam logic [3:0] SelH0   = 4'b1100;
  localparam logic [3:0] SelH1   = 4'b0011;
  localparam logic [3:0] SelW    = 4'b1111;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDone = 2'd2
  } lsu_state_e;

  function automatic logic is_load(input logic [7:0] op);
    return op inside {OpLb, OpLbu, OpLh, OpLhu, OpLw, OpLwl, OpLwr};
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    return op inside {OpSb, OpSh, OpSw, OpSwl, OpSwr};
  endfunction

  function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] lo);
    return ((op inside {OpLh, OpLhu, OpSh}) && lo[0]) ||
           ((op inside {OpLw, OpSw}) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_lsu_fmt.sv
// Byte-lane formatter: lane selects and store data alignment, plus load extraction/extension
// and LWL/LWR merging, all big-endian. Purely combinational.
module mem_lsu_fmt
  import mem_lsu_pkg::*;
(
  input  logic [7:0]  aluop_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] reg2_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  sel_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [1:0]  w_lo;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Halfword and word accesses ignore the low address bits they cannot use.
  always_comb begin
    w_lo = addr_lo_i;
    if (aluop_i inside {OpLh, OpLhu, OpSh}) begin
      w_lo[0] = 1'b0;
    end else if (aluop_i inside {OpLw, OpSw}) begin
      w_lo = 2'b00;
    end
    w_byte = rdata_i[{~w_lo, 3'b000} +: 8];
    w_half = w_lo[1] ? rdata_i[15:0] : rdata_i[31:16];
  end

  always_comb begin
    sel_o   = SelNone;
    wdata_o = '0;
    rdata_o = '0;
    case (aluop_i)
      OpLb:  begin sel_o = SelB0 >> w_lo; rdata_o = {{24{w_byte[7]}}, w_byte}; end
      OpLbu: begin sel_o = SelB0 >> w_lo; rdata_o = {24'h0, w_byte}; end
      OpLh:  begin sel_o = w_lo[1] ? SelH1 : SelH0; rdata_o = {{16{w_half[15]}}, w_half}; end
      OpLhu: begin sel_o = w_lo[1] ? SelH1 : SelH0; rdata_o = {16'h0, w_half}; end
      OpLw:  begin sel_o = SelW; rdata_o = rdata_i; end
      OpLwl: begin
        sel_o   = SelW;
        rdata_o = (rdata_i << {w_lo, 3'b000}) |
                  (reg2_i & ~(32'hFFFF_FFFF << {w_lo, 3'b000}));
      end
      OpLwr: begin
        sel_o   = SelW;
        rdata_o = (rdata_i >> {~w_lo, 3'b000}) |
                  (reg2_i & ~(32'hFFFF_FFFF >> {~w_lo, 3'b000}));
      end
      OpSb:  begin sel_o = SelB0 >> w_lo; wdata_o = {4{reg2_i[7:0]}}; end
      OpSh:  begin sel_o = w_lo[1] ? SelH1 : SelH0; wdata_o = {2{reg2_i[15:0]}}; end
      OpSw:  begin sel_o = SelW; wdata_o = reg2_i; end
      OpSwl: begin sel_o = SelW >> w_lo; wdata_o = reg2_i >> {w_lo, 3'b000}; end
      OpSwr: begin sel_o = SelW << ~w_lo; wdata_o = reg2_i << {~w_lo, 3'b000}; end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: IDLE/WAIT/DONE bus handshake with timeout and stall.
// Define MEM_LSU_ALIGN_EXC_EN to trap misaligned LH/LHU/LW/SH/SW instead of force-aligning them.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned TMR_W       = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wreg_i,
  input  logic [4:0]  wd_i,
  input  logic [31:0] wdata_i,
  input  logic        whilo_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  output logic        wreg_o,
  output logic [4:0]  wd_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        stall_req_o,
  output logic        exc_adel_o,
  output logic        exc_ades_o,
  output logic        bus_err_o
);

  lsu_state_e r_state;
  logic [TMR_W-1:0] r_cnt;
  logic        r_we, r_load, r_err;
  logic [31:0] r_addr, r_wdata, r_result;
  logic [3:0]  r_sel;

  logic        w_is_load, w_is_store, w_misal, w_start, w_timeout;
  logic [3:0]  w_sel;
  logic [31:0] w_wdata, w_rdata_fmt, w_addr, w_bus_wdata;
  logic [TMR_W-1:0] w_cnt_nxt;

  assign w_is_load  = is_load(aluop_i);
  assign w_is_store = is_store(aluop_i);
`ifdef MEM_LSU_ALIGN_EXC_EN
  assign w_misal = is_misaligned(aluop_i, mem_addr_i[1:0]);
`else
  assign w_misal = 1'b0;
`endif
  assign w_start     = (r_state == StIdle) && (w_is_load || w_is_store) && !w_misal;
  assign w_addr      = {mem_addr_i[31:2], 2'b00};
  assign w_bus_wdata = w_is_store ? w_wdata : '0;
  assign w_cnt_nxt   = r_cnt + 1'b1;
  assign w_timeout   = (w_cnt_nxt == TMR_W'(TIMEOUT_CYC));

  mem_lsu_fmt u_fmt (
    .aluop_i   (aluop_i),
    .addr_lo_i (mem_addr_i[1:0]),
    .reg2_i    (reg2_i),
    .rdata_i   (bus_rdata_i),
    .sel_o     (w_sel),
    .wdata_o   (w_wdata),
    .rdata_o   (w_rdata_fmt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_we     <= 1'b0;
      r_load   <= 1'b0;
      r_err    <= 1'b0;
      r_addr   <= '0;
      r_sel    <= SelNone;
      r_wdata  <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_start) begin
            r_state  <= StWait;
            r_cnt    <= '0;
            r_we     <= w_is_store;
            r_load   <= w_is_load;
            r_err    <= 1'b0;
            r_addr   <= w_addr;
            r_sel    <= w_sel;
            r_wdata  <= w_bus_wdata;
            r_result <= '0;
          end
        end
        StWait: begin
          r_cnt <= w_cnt_nxt;
          // Ack takes priority over a timeout landing in the same cycle.
          if (bus_ack_i) begin
            r_state  <= StDone;
            r_result <= r_load ? w_rdata_fmt : '0;
          end else if (w_timeout) begin
            r_state <= StDone;
            r_err   <= 1'b1;
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_err   <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_comb begin
    wreg_o      = wreg_i;
    wd_o        = wd_i;
    wdata_o     = wdata_i;
    whilo_o     = whilo_i;
    hi_o        = hi_i;
    lo_o        = lo_i;
    bus_req_o   = 1'b0;
    bus_we_o    = 1'b0;
    bus_addr_o  = '0;
    bus_sel_o   = SelNone;
    bus_wdata_o = '0;
    stall_req_o = 1'b0;
    exc_adel_o  = 1'b0;
    exc_ades_o  = 1'b0;
    bus_err_o   = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_is_load || w_is_store) begin
          wreg_o  = 1'b0;
          wdata_o = '0;
          if (w_misal) begin
            exc_adel_o = w_is_load;
            exc_ades_o = w_is_store;
          end else begin
            bus_req_o   = 1'b1;
            bus_we_o    = w_is_store;
            bus_addr_o  = w_addr;
            bus_sel_o   = w_sel;
            bus_wdata_o = w_bus_wdata;
            stall_req_o = 1'b1;
          end
        end
      end
      StWait: begin
        wreg_o      = 1'b0;
        wdata_o     = '0;
        bus_req_o   = 1'b1;
        bus_we_o    = r_we;
        bus_addr_o  = r_addr;
        bus_sel_o   = r_sel;
        bus_wdata_o = r_wdata;
        stall_req_o = 1'b1;
      end
      StDone: begin
        wreg_o    = r_load && wreg_i && !r_err;
        wdata_o   = r_result;
        bus_err_o = r_err;
      end
      default: ;
    endcase
    if (rst) begin
      wreg_o      = 1'b0;
      wd_o        = '0;
      wdata_o     = '0;
      whilo_o     = 1'b0;
      hi_o        = '0;
      lo_o        = '0;
      bus_req_o   = 1'b0;
      bus_we_o    = 1'b0;
      bus_addr_o  = '0;
      bus_sel_o   = SelNone;
      bus_wdata_o = '0;
      stall_req_o = 1'b0;
      exc_adel_o  = 1'b0;
      exc_ades_o  = 1'b0;
      bus_err_o   = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed corner cases plus randomized accesses
// against a byte-level big-endian memory model.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wreg_i, whilo_i, bus_ack_i;
  logic [4:0]  wd_i;
  logic [7:0]  aluop_i;
  logic [31:0] wdata_i, hi_i, lo_i, mem_addr_i, reg2_i, bus_rdata_i;
  logic        wreg_o, whilo_o, bus_req_o, bus_we_o, stall_req_o, exc_adel_o, exc_ades_o;
  logic        bus_err_o;
  logic [4:0]  wd_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] wdata_o, hi_o, lo_o, bus_addr_o, bus_wdata_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] ops [12] = '{OpLb, OpLbu, OpLh, OpLhu, OpLw, OpLwl, OpLwr,
                           OpSb, OpSh, OpSw, OpSwl, OpSwr};

  mem_lsu #(.TIMEOUT_CYC(64), .TMR_W(7)) dut (
    .clk(clk), .rst(rst),
    .wreg_i(wreg_i), .wd_i(wd_i), .wdata_i(wdata_i), .whilo_i(whilo_i), .hi_i(hi_i),
    .lo_i(lo_i), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
    .wreg_o(wreg_o), .wd_o(wd_o), .wdata_o(wdata_o), .whilo_o(whilo_o), .hi_o(hi_o),
    .lo_o(lo_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i),
    .bus_ack_i(bus_ack_i), .stall_req_o(stall_req_o), .exc_adel_o(exc_adel_o),
    .exc_ades_o(exc_ades_o), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory byte n of a word lives in bits [31-8n -: 8].
  function automatic logic [7:0] get_lane(input logic [31:0] w, input int lane);
    return w[31-8*lane -: 8];
  endfunction

  function automatic logic [31:0] put_lane(input logic [31:0] w, input int lane,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    r[31-8*lane -: 8] = b;
    return r;
  endfunction

  function automatic logic m_load(input logic [7:0] op);
    return op inside {OpLb, OpLbu, OpLh, OpLhu, OpLw, OpLwl, OpLwr};
  endfunction

  function automatic int eff_lane(input logic [7:0] op, input logic [31:0] a);
    int l;
    l = int'(a % 4);
    if (op inside {OpLh, OpLhu, OpSh}) l = l - (l % 2);
    if (op inside {OpLw, OpSw}) l = 0;
    return l;
  endfunction

  function automatic logic [3:0] m_sel(input logic [7:0] op, input logic [31:0] a);
    logic [3:0] s;
    int l;
    l = eff_lane(op, a);
    s = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if ((op inside {OpLb, OpLbu, OpSb}) && i == l) s[3-i] = 1'b1;
      if ((op inside {OpLh, OpLhu, OpSh}) && (i == l || i == l + 1)) s[3-i] = 1'b1;
      if (op inside {OpLw, OpSw, OpLwl, OpLwr}) s[3-i] = 1'b1;
      if (op == OpSwl && i >= l) s[3-i] = 1'b1;
      if (op == OpSwr && i <= l) s[3-i] = 1'b1;
    end
    return s;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [7:0] op, input logic [31:0] a,
                                          input logic [31:0] r2);
    logic [31:0] w;
    int l;
    l = eff_lane(op, a);
    w = 32'h0;
    case (op)
      OpSb: for (int i = 0; i < 4; i++) w = put_lane(w, i, r2[7:0]);
      OpSh: for (int i = 0; i < 4; i++) w = put_lane(w, i, get_lane(r2, 2 + (i % 2)));
      OpSw: w = r2;
      OpSwl: for (int k = 0; k <= 3 - l; k++) w = put_lane(w, l + k, get_lane(r2, k));
      OpSwr: for (int k = 0; k <= l; k++) w = put_lane(w, l - k, get_lane(r2, 3 - k));
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] m_result(input logic [7:0] op, input logic [31:0] a,
                                           input logic [31:0] rd, input logic [31:0] r2);
    logic [31:0] r;
    logic [15:0] h;
    int l;
    l = eff_lane(op, a);
    h = {get_lane(rd, l), get_lane(rd, (l + 1) % 4)};
    r = 32'h0;
    case (op)
      OpLb:  r = 32'($signed(get_lane(rd, l)));
      OpLbu: r = 32'(get_lane(rd, l));
      OpLh:  r = 32'($signed(h));
      OpLhu: r = 32'(h);
      OpLw:  r = rd;
      OpLwl: begin
        r = r2;
        for (int k = 0; k <= 3 - l; k++) r = put_lane(r, k, get_lane(rd, l + k));
      end
      OpLwr: begin
        r = r2;
        for (int k = 0; k <= l; k++) r = put_lane(r, 3 - k, get_lane(rd, l - k));
      end
      default: r = 32'h0;
    endcase
    return r;
  endfunction

`ifdef MEM_LSU_ALIGN_EXC_EN
  function automatic logic m_misal(input logic [7:0] op, input logic [31:0] a);
    return ((op inside {OpLh, OpLhu, OpSh}) && (a % 2 != 0)) ||
           ((op inside {OpLw, OpSw}) && (a % 4 != 0));
  endfunction
`endif

  task automatic nop_cycle();
    @(negedge clk);
    aluop_i = 8'($urandom_range(0, 127));
    wreg_i = 1'($urandom); wd_i = 5'($urandom); wdata_i = $urandom; whilo_i = 1'($urandom);
    hi_i = $urandom; lo_i = $urandom; mem_addr_i = $urandom; reg2_i = $urandom;
    bus_ack_i = 1'($urandom); bus_rdata_i = $urandom;
    #1;
    chk("nop_ctl", {wreg_o, wd_o, whilo_o}, {wreg_i, wd_i, whilo_i});
    chk("nop_wdata", wdata_o, wdata_i);
    chk("nop_hilo", hi_o ^ lo_o, hi_i ^ lo_i);
    chk("nop_bus", {bus_req_o, stall_req_o, bus_err_o, bus_sel_o}, 0);
  endtask

  task automatic access(input logic [7:0] op, input logic [31:0] a, input logic [31:0] r2,
                        input logic [31:0] rd, input int ack_after);
    logic        ld;
    logic [3:0]  e_sel;
    logic [31:0] e_wd;
    int          stalls;
    ld    = m_load(op);
    e_sel = m_sel(op, a);
    e_wd  = m_wdata(op, a, r2);
    @(negedge clk);
    aluop_i = op; mem_addr_i = a; reg2_i = r2; wreg_i = ld; wd_i = 5'($urandom);
    bus_ack_i = 1'b0; bus_rdata_i = $urandom;
    #1;
`ifdef MEM_LSU_ALIGN_EXC_EN
    if (m_misal(op, a)) begin
      chk("exc_flags", {exc_adel_o, exc_ades_o}, {ld, !ld});
      chk("exc_noreq", {bus_req_o, stall_req_o, wreg_o}, 0);
      return;
    end
`endif
    chk("exc_none", {exc_adel_o, exc_ades_o}, 0);
    stalls = int'(stall_req_o);
    chk("idle_req", {bus_req_o, bus_we_o}, {1'b1, !ld});
    chk("idle_addr", bus_addr_o, {a[31:2], 2'b00});
    chk("idle_sel", bus_sel_o, e_sel);
    chk("idle_wdata", bus_wdata_o, e_wd);
    for (int w = 0; w <= ack_after; w++) begin
      @(negedge clk);
      bus_ack_i   = (w == ack_after);
      bus_rdata_i = (w == ack_after) ? rd : $urandom;
      #1;
      stalls += int'(stall_req_o);
      chk("wait_req", {bus_req_o, bus_we_o, bus_sel_o}, {1'b1, !ld, e_sel});
      chk("wait_addr", bus_addr_o, {a[31:2], 2'b00});
      chk("wait_wdata", bus_wdata_o, e_wd);
      chk("wait_wd", wd_o, wd_i);
    end
    @(negedge clk);
    bus_ack_i = 1'b0; bus_rdata_i = $urandom;
    #1;
    chk("done_ctl", {stall_req_o, bus_req_o, bus_err_o}, 0);
    chk("done_wreg", wreg_o, ld);
    if (ld) chk("done_wdata", wdata_o, m_result(op, a, rd, r2));
    chk("stall_cycles", stalls, ack_after + 2);
  endtask

  initial begin
    int waits;
    aluop_i = OpLw; wreg_i = 1'b1; wd_i = 5'h1F; wdata_i = $urandom; whilo_i = 1'b1;
    hi_i = $urandom; lo_i = $urandom; mem_addr_i = 32'h40; reg2_i = $urandom;
    bus_rdata_i = $urandom; bus_ack_i = 1'b1;
    #1;
    chk("rst_ctl", {wreg_o, wd_o, whilo_o, bus_req_o, bus_we_o, stall_req_o, bus_sel_o,
                    exc_adel_o, exc_ades_o, bus_err_o}, 0);
    chk("rst_data", wdata_o | hi_o | lo_o | bus_addr_o | bus_wdata_o, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0; aluop_i = 8'h00; bus_ack_i = 1'b0;

    nop_cycle();
    access(OpLb, 32'h0000_0103, $urandom, 32'h1122_3380, 0);
    access(OpSwr, 32'h0000_0202, 32'hAABB_CCDD, $urandom, 5);
    access(OpLh, 32'h0000_0301, $urandom, 32'h8001_7FFE, 1);
    access(OpLw, 32'h0000_0500, $urandom, 32'hCAFE_F00D, 63);
    nop_cycle();

    // No ack at all: bus error after the full timeout window.
    access(OpLwl, 32'h0000_0001, 32'h0102_0304, 32'hA0B0_C0D0, 0);
    @(negedge clk);
    aluop_i = OpLw; mem_addr_i = 32'h0000_0400; wreg_i = 1'b1; bus_ack_i = 1'b0;
    waits = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      #1;
      if (bus_err_o) break;
      waits += int'(bus_req_o);
    end
    chk("to_err", bus_err_o, 1);
    chk("to_waits", waits, 64);
    chk("to_done", {wreg_o, stall_req_o, bus_req_o}, 0);
    nop_cycle();

    // Reset in the middle of WAIT, then a stray ack.
    @(negedge clk);
    aluop_i = OpLw; mem_addr_i = 32'h0000_0600; wreg_i = 1'b1; bus_ack_i = 1'b0;
    @(negedge clk); @(negedge clk);
    #1;
    chk("pre_rst_wait", {bus_req_o, stall_req_o}, 2'b11);
    rst = 1'b1; aluop_i = 8'h00; wreg_i = 1'b0; wd_i = '0; wdata_i = '0; whilo_i = 1'b0;
    hi_i = '0; lo_i = '0; mem_addr_i = '0; reg2_i = '0;
    #1;
    chk("midrst_out", {bus_req_o, stall_req_o, bus_sel_o, bus_err_o, wreg_o}, 0);
    @(negedge clk);
    rst = 1'b0; bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFF_FFFF;
    #1;
    chk("stray_ack", {bus_req_o, stall_req_o, bus_err_o, wreg_o}, 0);
    @(negedge clk);
    bus_ack_i = 1'b0;
    #1;
    chk("no_done", {bus_err_o, wreg_o, stall_req_o}, 0);
    chk("no_done_wdata", wdata_o, 0);
    nop_cycle();

    for (int n = 0; n < 40; n++) begin
      access(ops[$urandom_range(0, 11)], $urandom, $urandom, $urandom, $urandom_range(0, 4));
      if ($urandom_range(0, 1) == 1) nop_cycle();
    end
    nop_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
